stoch_bitstream_decoder: RTL

- Receiving end of the team's stochastic-number datapath: consumes a serial stochastic bitstream (e.g. an LFSR/comparator encoder or XNOR multiplier output) and converts it back to binary.
- Counts ones over a programmable power-of-two window and reports the unipolar count or the bipolar signed value (2*ones - N).
- Results are delivered through a valid/ready output with sticky overrun detection.
- Runs back-to-back windows with no dead cycles.

---
 rtl/stoch_bitstream_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/stoch_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// stoch_bitstream_decoder
//
// Converts a serial stochastic bitstream back to binary. Counts ones over a
// power-of-two window of accepted bits (N = 2^win_log2, clamped to 2..2^MAX_LOG2)
// and reports either the unipolar count or the bipolar value 2*ones - N.
// Windows run back to back: the edge that takes the Nth bit also restarts
// the counters, so the next window's first bit can arrive one cycle later.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           decoder enable; dropping it mid-window discards the window
//   win_log2     window size select (latched at window start)
//   mode         0 = unipolar, 1 = bipolar (latched at window start)
//   sn_valid     qualifies sn_bit
//   sn_bit       stochastic sample
//   out_valid    result available, held until accepted
//   out_ready    consumer accept
//   out_ones     ones count of the reported window
//   out_value    two's-complement result (ones or 2*ones-N)
//   out_bipolar  mode of the reported window
//   overrun      sticky: a result was overwritten before acceptance
//   clr_ovf      synchronous clear of overrun (a same-edge set wins)
// -----------------------------------------------------------------------------
module stoch_bitstream_decoder #(
  parameter int MAX_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [3:0]          win_log2,
  input  logic                mode,
  input  logic                sn_valid,
  input  logic                sn_bit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAX_LOG2:0]   out_ones,
  output logic [MAX_LOG2+1:0] out_value,
  output logic                out_bipolar,
  output logic                overrun,
  input  logic                clr_ovf
);

  localparam int CW = MAX_LOG2 + 1;  // counter width: holds 2^MAX_LOG2 exactly
  localparam int VW = MAX_LOG2 + 2;  // signed result width: -N..+N
  localparam logic [3:0] LP_MAX_LOG2 = 4'(MAX_LOG2);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_log2, w_log2_next;
  logic            r_mode, w_mode_next;
  logic [CW-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [CW-1:0]   r_ones_cnt, w_ones_cnt_next;
  logic            r_out_valid, w_out_valid_next;
  logic [CW-1:0]   r_out_ones, w_out_ones_next;
  logic [VW-1:0]   r_out_value, w_out_value_next;
  logic            r_out_bipolar, w_out_bipolar_next;
  logic            r_overrun, w_overrun_next;

  logic [3:0]      w_log2_clamp;
  logic [CW-1:0]   w_n;
  logic [CW-1:0]   w_bit_cnt_inc;
  logic [CW-1:0]   w_ones_inc;
  logic            w_last;
  logic            w_xfer;
  logic [VW-1:0]   w_uni_value;
  logic [VW-1:0]   w_bip_value;

  // Smallest legal window is 2, largest 2^MAX_LOG2.
  always_comb begin
    w_log2_clamp = win_log2;
    if (win_log2 == 4'd0) begin
      w_log2_clamp = 4'd1;
    end else if (win_log2 > LP_MAX_LOG2) begin
      w_log2_clamp = LP_MAX_LOG2;
    end
  end

  assign w_n           = {{(CW-1){1'b0}}, 1'b1} << r_log2;
  assign w_bit_cnt_inc = r_bit_cnt + {{(CW-1){1'b0}}, 1'b1};
  assign w_ones_inc    = r_ones_cnt + {{(CW-1){1'b0}}, sn_bit};
  assign w_last        = (r_state == ST_ACCUM) && en && sn_valid && (w_bit_cnt_inc == w_n);
  assign w_xfer        = r_out_valid && out_ready;

  // 2*ones fits unsigned in VW bits; the modular subtraction lands on the
  // correct signed value because the true result lies within -N..+N.
  assign w_uni_value = {1'b0, w_ones_inc};
  assign w_bip_value = {w_ones_inc, 1'b0} - {1'b0, w_n};

  always_comb begin
    w_state_next       = r_state;
    w_log2_next        = r_log2;
    w_mode_next        = r_mode;
    w_bit_cnt_next     = r_bit_cnt;
    w_ones_cnt_next    = r_ones_cnt;
    w_out_ones_next    = r_out_ones;
    w_out_value_next   = r_out_value;
    w_out_bipolar_next = r_out_bipolar;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_next    = ST_ACCUM;
          w_log2_next     = w_log2_clamp;
          w_mode_next     = mode;
          w_bit_cnt_next  = '0;
          w_ones_cnt_next = '0;
        end
      end
      ST_ACCUM: begin
        if (!en) begin
          // Partial window dropped; output registers left alone.
          w_state_next    = ST_IDLE;
          w_bit_cnt_next  = '0;
          w_ones_cnt_next = '0;
        end else if (w_last) begin
          w_out_ones_next    = w_ones_inc;
          w_out_value_next   = r_mode ? w_bip_value : w_uni_value;
          w_out_bipolar_next = r_mode;
          w_bit_cnt_next     = '0;
          w_ones_cnt_next    = '0;
          w_log2_next        = w_log2_clamp;
          w_mode_next        = mode;
        end else if (sn_valid) begin
          w_bit_cnt_next  = w_bit_cnt_inc;
          w_ones_cnt_next = w_ones_inc;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A completing window always leaves a valid result, even if the old one
    // is transferred on the same edge.
    if (w_last) begin
      w_out_valid_next = 1'b1;
    end else if (w_xfer) begin
      w_out_valid_next = 1'b0;
    end else begin
      w_out_valid_next = r_out_valid;
    end

    // Setting takes priority over a simultaneous clear.
    if (w_last && r_out_valid && !out_ready) begin
      w_overrun_next = 1'b1;
    end else if (clr_ovf) begin
      w_overrun_next = 1'b0;
    end else begin
      w_overrun_next = r_overrun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_log2        <= 4'd1;
      r_mode        <= 1'b0;
      r_bit_cnt     <= '0;
      r_ones_cnt    <= '0;
      r_out_valid   <= 1'b0;
      r_out_ones    <= '0;
      r_out_value   <= '0;
      r_out_bipolar <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_log2        <= w_log2_next;
      r_mode        <= w_mode_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_ones_cnt    <= w_ones_cnt_next;
      r_out_valid   <= w_out_valid_next;
      r_out_ones    <= w_out_ones_next;
      r_out_value   <= w_out_value_next;
      r_out_bipolar <= w_out_bipolar_next;
      r_overrun     <= w_overrun_next;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_ones    = r_out_ones;
  assign out_value   = r_out_value;
  assign out_bipolar = r_out_bipolar;
  assign overrun     = r_overrun;

endmodule
